// File: rtl/unsat_clause_picker.sv
`default_nettype none
// unsat_clause_picker: drains FIFO_Tree unsat clauses each round, then offers one picked by (lfsr*count)>>16.
// Optional feature macro PICKER_SEED_LOAD_EN adds seed_i/seed_load_i for runtime LFSR reseeding.
module unsat_clause_picker #(
  parameter int          CLAUSE_WIDTH = 9,
  parameter int          BUF_DEPTH    = 32,
  parameter int          IDLE_TIMEOUT = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         CW           = $clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    tree_empty_i,
  input  logic                    tree_of_i,
  input  logic [CLAUSE_WIDTH-1:0] tree_clause_i,
  output logic                    tree_rd_en_o,
  output logic                    tree_cof_o,
  output logic [CLAUSE_WIDTH-1:0] clause_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    none_o,
  output logic                    of_o,
  output logic [CW-1:0]           count_o,
  output logic                    busy_o
`ifdef PICKER_SEED_LOAD_EN
  ,
  input  logic [15:0]             seed_i,
  input  logic                    seed_load_i
`endif
);

  localparam int          IW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int          TW        = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [15:0] SEED_SAFE = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [CW-1:0] FULL    = CW'(BUF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_CLEAR = 3'd2,
    S_PICK  = 3'd3,
    S_FETCH = 3'd4,
    S_OFFER = 3'd5
  } state_t;

  state_t                  state;
  logic [15:0]             lfsr;
  logic [CW-1:0]           count;
  logic [TW-1:0]           idle_cnt;
  logic [TW-1:0]           idle_inc;
  logic                    inflight;
  logic [IW-1:0]           idx;
  logic [16+CW-1:0]        prod;
  logic [CLAUSE_WIDTH-1:0] cap_buf [BUF_DEPTH];
  logic                    unused_bits;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // Read request follows the tree's empty flag directly so no grant is wasted.
  assign tree_rd_en_o = (state == S_DRAIN) && !tree_empty_i && !rst_i;
  assign idle_inc     = idle_cnt + TW'(1);
  assign prod         = {{CW{1'b0}}, lfsr} * {{16{1'b0}}, count};
  assign unused_bits  = ^{prod[15:0], prod[16+CW-1:16+IW]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= SEED_SAFE;
`ifdef PICKER_SEED_LOAD_EN
    end else if (seed_load_i) begin
      lfsr <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
`endif
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == S_DRAIN && inflight && count < FULL) begin
      cap_buf[count[IW-1:0]] <= tree_clause_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      count      <= '0;
      idle_cnt   <= '0;
      inflight   <= 1'b0;
      idx        <= '0;
      tree_cof_o <= 1'b0;
      clause_o   <= '0;
      valid_o    <= 1'b0;
      none_o     <= 1'b0;
      of_o       <= 1'b0;
      count_o    <= '0;
      busy_o     <= 1'b0;
    end else begin
      tree_cof_o <= 1'b0;
      none_o     <= 1'b0;
      inflight   <= tree_rd_en_o;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state    <= S_DRAIN;
            count    <= '0;
            of_o     <= 1'b0;
            idle_cnt <= '0;
            busy_o   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (tree_of_i) of_o <= 1'b1;
          // Entries past the buffer are still read so the tree empties, but flagged.
          if (inflight) begin
            if (count < FULL) count <= count + CW'(1);
            else              of_o  <= 1'b1;
          end
          if (tree_empty_i && !inflight) begin
            idle_cnt <= idle_inc;
            if (idle_inc == TW'(IDLE_TIMEOUT)) begin
              state      <= S_CLEAR;
              tree_cof_o <= 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        S_CLEAR: begin
          count_o <= count;
          if (count == '0) begin
            none_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else begin
            state <= S_PICK;
          end
        end
        S_PICK: begin
          idx   <= prod[16 +: IW];
          state <= S_FETCH;
        end
        S_FETCH: begin
          clause_o <= cap_buf[idx];
          valid_o  <= 1'b1;
          state    <= S_OFFER;
        end
        S_OFFER: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unsat_clause_picker.sv
`default_nettype none
// Bench for unsat_clause_picker: queue-based FIFO_Tree model, reference LFSR and scoreboard monitor.
module tb_unsat_clause_picker;

  localparam int IDLE_TIMEOUT = 4;
  localparam int BUF_DEPTH    = 32;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       tree_empty_i;
  logic       tree_of_i = 1'b0;
  logic [8:0] tree_clause_i = '0;
  logic       tree_rd_en_o;
  logic       tree_cof_o;
  logic [8:0] clause_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       none_o;
  logic       of_o;
  logic [5:0] count_o;
  logic       busy_o;
`ifdef PICKER_SEED_LOAD_EN
  logic [15:0] seed_i = '0;
  logic        seed_load_i = 1'b0;
`endif

  unsat_clause_picker dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .tree_empty_i(tree_empty_i),
    .tree_of_i(tree_of_i), .tree_clause_i(tree_clause_i), .tree_rd_en_o(tree_rd_en_o),
    .tree_cof_o(tree_cof_o), .clause_o(clause_o), .valid_o(valid_o), .ready_i(ready_i),
    .none_o(none_o), .of_o(of_o), .count_o(count_o), .busy_o(busy_o)
`ifdef PICKER_SEED_LOAD_EN
    , .seed_i(seed_i), .seed_load_i(seed_load_i)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO_Tree model: data appears the cycle after a granted read.
  logic [8:0] tree_mem [4096];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       tree_flush = 1'b0;
  assign tree_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (tree_flush) rd_ptr <= wr_ptr;
    else if (tree_rd_en_o) begin
      tree_clause_i <= tree_mem[rd_ptr % 4096];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Reference Galois LFSR; hist2 holds the value two cycles back (the PICK cycle when valid rises).
  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] m_lfsr, hist1, hist2;
  always @(posedge clk) begin
    hist1 <= m_lfsr;
    hist2 <= hist1;
    if (rst_i) m_lfsr <= 16'hACE1;
`ifdef PICKER_SEED_LOAD_EN
    else if (seed_load_i) m_lfsr <= (seed_i == 16'h0) ? 16'h1 : seed_i;
`endif
    else m_lfsr <= step(m_lfsr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  bit         exp_none_q[$];
  int         exp_cnt_q[$];
  bit         exp_of_q[$];
  int         exp_cyc_q[$];
  logic [8:0] exp_items [32];
  int         round_n = 0;

  logic       prev_valid = 1'b0;
  logic [8:0] held = '0;
  logic [8:0] last_pick = '0;
  int         done_cnt = 0;
  int         cof_cnt = 0;
  bit         cov [12];

  always @(negedge clk) begin
    bit e_none, e_of;
    int e_cnt, e_cyc, idx;
    int unsigned p;
    if (rst_i) begin
      prev_valid = 1'b0;
      cof_cnt    = 0;
    end else begin
      if (tree_cof_o) cof_cnt++;
      if (none_o || (valid_o && !prev_valid)) begin
        if (exp_none_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected_output actual=none:%0b valid:%0b required=no output", none_o, valid_o);
        end else begin
          e_none = exp_none_q.pop_front();
          e_cnt  = exp_cnt_q.pop_front();
          e_of   = exp_of_q.pop_front();
          e_cyc  = exp_cyc_q.pop_front();
          chk("out_kind_none", {31'd0, none_o}, {31'd0, e_none});
          chk("count_o", {26'd0, count_o}, e_cnt);
          chk("of_o", {31'd0, of_o}, {31'd0, e_of});
          chk("cof_once", cof_cnt, 1);
          cof_cnt = 0;
          if (none_o) begin
            chk("none_time", cyc, e_cyc);
            chk("none_valid", {31'd0, valid_o}, 0);
            done_cnt++;
          end else if (e_cnt > 0) begin
            p   = 32'(hist2) * 32'(e_cnt);
            idx = int'(p >> 16);
            chk("pick_clause", {23'd0, clause_o}, {23'd0, exp_items[idx]});
            held      = clause_o;
            last_pick = clause_o;
            if (e_cnt == 12) cov[idx] = 1'b1;
          end
        end
      end else if (valid_o) begin
        chk("clause_stable", {23'd0, clause_o}, {23'd0, held});
      end
      if (valid_o && ready_i) done_cnt++;
      prev_valid = valid_o;
    end
  end

  task automatic push_clause(input logic [8:0] v);
    tree_mem[wr_ptr % 4096] = v;
    if (round_n < 32) exp_items[round_n] = v;
    round_n++;
    wr_ptr++;
  endtask

  task automatic round(input bit of_pulse, input int stall, input bit load_seed);
    int before_rd, before_done, n, c0;
    n           = round_n;
    before_rd   = rd_ptr;
    before_done = done_cnt;
    ready_i     = (stall == 0);
    @(negedge clk);
    start_i = 1'b1;
`ifdef PICKER_SEED_LOAD_EN
    if (load_seed) begin seed_i = 16'h1234; seed_load_i = 1'b1; end
`else
    if (load_seed) start_i = 1'b1;
`endif
    @(posedge clk);
    #1;
    c0 = cyc;
    exp_none_q.push_back(n == 0);
    exp_cnt_q.push_back(n > BUF_DEPTH ? BUF_DEPTH : n);
    exp_of_q.push_back(of_pulse || n > BUF_DEPTH);
    exp_cyc_q.push_back(c0 + IDLE_TIMEOUT + 1);
    @(negedge clk);
    start_i = 1'b0;
`ifdef PICKER_SEED_LOAD_EN
    seed_load_i = 1'b0;
`endif
    if (of_pulse) begin
      tree_of_i = 1'b1;
      @(negedge clk);
      tree_of_i = 1'b0;
    end
    if (stall > 0) begin
      for (int k = 0; k < 300 && !valid_o; k++) @(negedge clk);
      repeat (stall) @(negedge clk);
      @(posedge clk);
      #1 ready_i = 1'b1;
    end
    for (int k = 0; k < 300 && done_cnt == before_done; k++) @(negedge clk);
    chk("round_done", done_cnt - before_done, 1);
    @(negedge clk);
    chk("busy_after", {31'd0, busy_o}, 0);
    chk("reads", rd_ptr - before_rd, n);
    round_n = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy_o}, 0);
    chk({tag, "_valid"}, {31'd0, valid_o}, 0);
    chk({tag, "_none"}, {31'd0, none_o}, 0);
    chk({tag, "_of"}, {31'd0, of_o}, 0);
    chk({tag, "_count"}, {26'd0, count_o}, 0);
    chk({tag, "_clause"}, {23'd0, clause_o}, 0);
    chk({tag, "_rd_en"}, {31'd0, tree_rd_en_o}, 0);
    chk({tag, "_cof"}, {31'd0, tree_cof_o}, 0);
  endtask

  initial begin
    logic [8:0] pick1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_i = 1'b0;
    @(negedge clk);
    chk_reset_outputs("idle");

    // three preloaded clauses
    push_clause(9'h011); push_clause(9'h022); push_clause(9'h033);
    round(1'b0, 0, 1'b0);

    // empty tree
    round(1'b0, 0, 1'b0);

    // overflow of the local buffer
    for (int i = 0; i < 40; i++) push_clause(9'(9'h100 + i));
    round(1'b0, 0, 1'b0);

    // tree overflow flag pulse, then a clean round clears of_o
    for (int i = 0; i < 5; i++) push_clause(9'(9'h040 + i));
    round(1'b1, 0, 1'b0);
    for (int i = 0; i < 5; i++) push_clause(9'(9'h050 + i));
    round(1'b0, 0, 1'b0);

    // consumer stall
    for (int i = 0; i < 7; i++) push_clause(9'(9'h0A0 + i * 3));
    round(1'b0, 10, 1'b0);

    // reset mid-drain
    for (int i = 0; i < 10; i++) push_clause(9'(9'h1C0 + i));
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    #1 chk("rst_rd_en_same_cycle", {31'd0, tree_rd_en_o}, 0);
    @(negedge clk);
    chk_reset_outputs("midrst");
    tree_flush = 1'b1;
    rst_i      = 1'b0;
    @(negedge clk);
    tree_flush = 1'b0;
    round_n    = 0;

    // index coverage over many 12-clause rounds
    for (int r = 0; r < 1000; r++) begin
      for (int j = 0; j < 12; j++) push_clause(9'((r * 12 + j) & 9'h1FF));
      round(1'b0, 0, 1'b0);
    end
    for (int j = 0; j < 12; j++) chk($sformatf("cover_idx%0d", j), {31'd0, cov[j]}, 1);

`ifdef PICKER_SEED_LOAD_EN
    for (int i = 0; i < 9; i++) push_clause(9'(9'h070 + i));
    round(1'b0, 0, 1'b1);
    pick1 = last_pick;
    for (int i = 0; i < 9; i++) push_clause(9'(9'h070 + i));
    round(1'b0, 0, 1'b1);
    chk("seed_repeat", {23'd0, last_pick}, {23'd0, pick1});
`else
    pick1 = last_pick;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
